// File: rtl/codec_config_sequencer.sv
// Walks a configuration table and issues one I2C write per entry,
// pacing entries with a fixed gap and guarding each controller phase with a timeout.
module codec_config_sequencer #(
  parameter int unsigned NUM_ENTRIES    = 8,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [14:0] rom_data,
  input  logic [3:0]  ctrl_state,
  output logic [3:0]  rom_index,
  output logic        enable,
  output logic        mode,
  output logic [6:0]  periph_addr,
  output logic [7:0]  transmit_byte,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned IDX_W  = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_REQUEST   = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4,
    S_DONE      = 3'd5,
    S_ERROR     = 3'd6
  } state_e;

  state_e              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [CNT_W-1:0]    tmo_q;
  logic [CNT_W-1:0]    gap_q;
  logic                enable_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   byte_q;
  logic                busy_q;
  logic                done_q;
  logic                error_q;
  logic                ctrl_idle;

  assign ctrl_idle = (ctrl_state == 4'd0);

  // Sequencer: every output is updated together with the state it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      tmo_q    <= '0;
      gap_q    <= '0;
      enable_q <= 1'b0;
      addr_q   <= '0;
      byte_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state_q <= S_LOAD;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
          end
        end
        S_LOAD: begin
          addr_q   <= rom_data[14:8];
          byte_q   <= rom_data[7:0];
          tmo_q    <= '0;
          enable_q <= 1'b1;
          state_q  <= S_REQUEST;
        end
        S_REQUEST: begin
          if (!ctrl_idle) begin
            enable_q <= 1'b0;
            tmo_q    <= '0;
            state_q  <= S_WAIT_DONE;
          end else if (tmo_q == TO_LAST) begin
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            error_q  <= 1'b1;
            state_q  <= S_ERROR;
          end else begin
            tmo_q <= tmo_q + CNT_W'(1);
          end
        end
        S_WAIT_DONE: begin
          // A completion seen on the last timeout cycle still counts as success.
          if (ctrl_idle) begin
            if (idx_q < LAST_IDX) begin
              gap_q   <= '0;
              state_q <= S_GAP;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end else if (tmo_q == TO_LAST) begin
            busy_q  <= 1'b0;
            error_q <= 1'b1;
            state_q <= S_ERROR;
          end else begin
            tmo_q <= tmo_q + CNT_W'(1);
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            idx_q   <= idx_q + IDX_W'(1);
            state_q <= S_LOAD;
          end else begin
            gap_q <= gap_q + CNT_W'(1);
          end
        end
        default: begin
          state_q  <= S_IDLE;
          idx_q    <= '0;
          tmo_q    <= '0;
          gap_q    <= '0;
          enable_q <= 1'b0;
          addr_q   <= '0;
          byte_q   <= '0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
          error_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rom_index     = idx_q;
  assign enable        = enable_q;
  assign mode          = 1'b1;
  assign periph_addr   = addr_q;
  assign transmit_byte = byte_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Bench for codec_config_sequencer: a timeline model checks instance A every cycle,
// instance B (single entry, short timeout) is checked with directed literals.
module tb_codec_config_sequencer;

  localparam int unsigned A_N   = 3;
  localparam int unsigned A_GAP = 4;
  localparam int unsigned A_TO  = 255;

  logic        clk;
  logic        reset_a, start_a, reset_b, start_b;
  logic [14:0] rom_a, rom_b;
  logic [3:0]  ctrl_a, ctrl_b;
  logic [3:0]  a_rom_index, b_rom_index;
  logic        a_enable, a_mode, a_busy, a_done, a_error;
  logic        b_enable, b_mode, b_busy, b_done, b_error;
  logic [6:0]  a_periph_addr, b_periph_addr;
  logic [7:0]  a_transmit_byte, b_transmit_byte;

  int checks = 0;
  int errors = 0;
  int rel    = 0;
  int ctrl_mode = 0;

  codec_config_sequencer #(.NUM_ENTRIES(A_N), .GAP_CYCLES(A_GAP), .TIMEOUT_CYCLES(A_TO)) u_a (
    .clk(clk), .reset(reset_a), .start(start_a), .rom_data(rom_a), .ctrl_state(ctrl_a),
    .rom_index(a_rom_index), .enable(a_enable), .mode(a_mode), .periph_addr(a_periph_addr),
    .transmit_byte(a_transmit_byte), .busy(a_busy), .done(a_done), .error(a_error));

  codec_config_sequencer #(.NUM_ENTRIES(1), .GAP_CYCLES(4), .TIMEOUT_CYCLES(10)) u_b (
    .clk(clk), .reset(reset_b), .start(start_b), .rom_data(rom_b), .ctrl_state(ctrl_b),
    .rom_index(b_rom_index), .enable(b_enable), .mode(b_mode), .periph_addr(b_periph_addr),
    .transmit_byte(b_transmit_byte), .busy(b_busy), .done(b_done), .error(b_error));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] rom_addr(input int i);
    return 7'(32 + 5 * i);
  endfunction

  function automatic logic [7:0] rom_byte(input int i);
    return 8'h81 ^ 8'(19 * i);
  endfunction

  always_comb rom_a = {rom_addr(int'(a_rom_index)), rom_byte(int'(a_rom_index))};
  always_comb rom_b = {rom_addr(int'(b_rom_index)), rom_byte(int'(b_rom_index))};

  // Controller stub for A: leaves idle 3 cycles after enable, busy for 40 cycles.
  initial begin
    bit hang;
    ctrl_a = 4'd0;
    forever begin
      @(negedge clk);
      if (reset_a || !a_enable) continue;
      hang = (ctrl_mode == 2) && (a_rom_index == 4'd1);
      repeat (3) @(posedge clk);
      #1 ctrl_a = 4'd5;
      if (hang) begin
        while (ctrl_mode == 2 && !reset_a) @(posedge clk);
      end else begin
        for (int k = 0; k < 40 && !reset_a; k++) @(posedge clk);
      end
      #1 ctrl_a = 4'd0;
    end
  end

  // Timeline model of A: what the outputs must be after each rising edge.
  logic [3:0] m_idx;
  logic       m_en, m_busy, m_done, m_err;
  logic [6:0] m_addr;
  logic [7:0] m_byte;

  task automatic m_rst();
    m_idx = 4'd0; m_en = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
    m_addr = 7'd0; m_byte = 8'd0;
  endtask

  task automatic mtick(output bit ab);
    @(posedge clk);
    ab = reset_a;
    if (ab) m_rst();
  endtask

  task automatic m_run();
    bit ab;
    bit ok;
    m_done = 1'b0; m_err = 1'b0; m_busy = 1'b1; m_en = 1'b0;
    for (int e = 0; e < int'(A_N); e++) begin
      m_idx = 4'(e);
      mtick(ab); if (ab) return;
      m_addr = rom_addr(e); m_byte = rom_byte(e); m_en = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < int'(A_TO) && !ok; k++) begin
        mtick(ab); if (ab) return;
        ok = (ctrl_a != 4'd0);
      end
      m_en = 1'b0;
      if (!ok) begin m_busy = 1'b0; m_err = 1'b1; return; end
      ok = 1'b0;
      for (int k = 0; k < int'(A_TO) && !ok; k++) begin
        mtick(ab); if (ab) return;
        ok = (ctrl_a == 4'd0);
      end
      if (!ok) begin m_busy = 1'b0; m_err = 1'b1; return; end
      if (e == int'(A_N) - 1) begin m_busy = 1'b0; m_done = 1'b1; return; end
      for (int g = 0; g < int'(A_GAP); g++) begin
        mtick(ab); if (ab) return;
      end
    end
  endtask

  initial begin
    m_rst();
    forever begin
      @(posedge clk);
      if (reset_a) m_rst();
      else if (start_a) m_run();
    end
  end

  // Every-cycle comparison of A against the model.
  initial begin
    logic [23:0] act, exp;
    forever begin
      @(negedge clk);
      act = {a_rom_index, a_enable, a_mode, a_periph_addr, a_transmit_byte, a_busy, a_done, a_error};
      if (reset_a) exp = {4'd0, 1'b0, 1'b1, 7'd0, 8'd0, 1'b0, 1'b0, 1'b0};
      else         exp = {m_idx, m_en, 1'b1, m_addr, m_byte, m_busy, m_done, m_err};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL model_cmp t=%0t act=%h exp=%h", $time, act, exp);
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t act=%0h exp=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic adv(input int k);
    while (rel < k) begin
      @(posedge clk);
      rel++;
    end
  endtask

  task automatic pulse_a();
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); rel = 0; #1 start_a = 1'b0;
  endtask

  initial begin
    reset_a = 1'b1; reset_b = 1'b1; start_a = 1'b0; start_b = 1'b0; ctrl_b = 4'd0;
    repeat (3) @(posedge clk);
    #1 reset_a = 1'b0;
    @(negedge clk);
    chk("rst_busy", 16'(a_busy), 16'd0);
    chk("rst_idx", 16'(a_rom_index), 16'd0);
    chk("rst_mode", 16'(a_mode), 16'd1);
    chk("rst_en", 16'(a_enable), 16'd0);

    // Nominal three-entry run with ignored start pulses in WAIT_DONE and GAP
    pulse_a();
    adv(1); @(negedge clk);
    chk("lat_en", 16'(a_enable), 16'd1);
    chk("e0_addr", 16'(a_periph_addr), 16'h20);
    chk("e0_byte", 16'(a_transmit_byte), 16'h81);
    adv(4); @(negedge clk); chk("en_hold", 16'(a_enable), 16'd1);
    adv(5); @(negedge clk); chk("en_drop", 16'(a_enable), 16'd0);
    adv(19); #1 start_a = 1'b1; adv(20); #1 start_a = 1'b0;
    adv(46); #1 start_a = 1'b1; adv(47); #1 start_a = 1'b0;
    adv(50); @(negedge clk);
    chk("e1_idx", 16'(a_rom_index), 16'd1);
    chk("e1_en", 16'(a_enable), 16'd1);
    chk("e1_addr", 16'(a_periph_addr), 16'h25);
    chk("e1_byte", 16'(a_transmit_byte), 16'h92);
    adv(99); @(negedge clk);
    chk("e2_idx", 16'(a_rom_index), 16'd2);
    chk("e2_addr", 16'(a_periph_addr), 16'h2A);
    chk("e2_byte", 16'(a_transmit_byte), 16'hA7);
    adv(142); @(negedge clk); chk("pre_done", 16'(a_done), 16'd0);
    adv(143); @(negedge clk);
    chk("done", 16'(a_done), 16'd1);
    chk("done_busy", 16'(a_busy), 16'd0);
    chk("done_idx", 16'(a_rom_index), 16'd2);

    // Controller never returns on entry 1
    adv(150);
    ctrl_mode = 2;
    pulse_a();
    adv(1); @(negedge clk);
    chk("r2_done_clr", 16'(a_done), 16'd0);
    chk("r2_idx", 16'(a_rom_index), 16'd0);
    adv(308); @(negedge clk);
    chk("wto_pre_err", 16'(a_error), 16'd0);
    chk("wto_pre_busy", 16'(a_busy), 16'd1);
    adv(309); @(negedge clk);
    chk("wto_err", 16'(a_error), 16'd1);
    chk("wto_idx", 16'(a_rom_index), 16'd1);
    chk("wto_busy", 16'(a_busy), 16'd0);
    chk("wto_en", 16'(a_enable), 16'd0);
    ctrl_mode = 0;
    adv(312);

    // Restart from error, then reset during entry 1 WAIT_DONE
    pulse_a();
    adv(1); @(negedge clk);
    chk("r3_err_clr", 16'(a_error), 16'd0);
    chk("r3_idx", 16'(a_rom_index), 16'd0);
    chk("r3_addr", 16'(a_periph_addr), 16'h20);
    adv(69); @(negedge clk);
    chk("mid_idx", 16'(a_rom_index), 16'd1);
    chk("mid_busy", 16'(a_busy), 16'd1);
    adv(70); #1 reset_a = 1'b1; #1;
    chk("arst_idx", 16'(a_rom_index), 16'd0);
    chk("arst_addr", 16'(a_periph_addr), 16'd0);
    chk("arst_byte", 16'(a_transmit_byte), 16'd0);
    chk("arst_busy", 16'(a_busy), 16'd0);
    chk("arst_flags", {14'd0, a_done, a_error}, 16'd0);
    chk("arst_mode", 16'(a_mode), 16'd1);
    adv(73); #1 reset_a = 1'b0;
    pulse_a();
    adv(1); @(negedge clk);
    chk("r4_idx", 16'(a_rom_index), 16'd0);
    chk("r4_en", 16'(a_enable), 16'd1);
    chk("r4_byte", 16'(a_transmit_byte), 16'h81);
    adv(150); @(negedge clk);
    chk("r4_done", 16'(a_done), 16'd1);

    // Instance B: timeout in REQUEST after 10 cycles
    @(posedge clk); #1 reset_b = 1'b0;
    @(negedge clk);
    chk("b_rst_busy", 16'(b_busy), 16'd0);
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); rel = 0; #1 start_b = 1'b0;
    adv(10); @(negedge clk);
    chk("b_req_en", 16'(b_enable), 16'd1);
    chk("b_req_err", 16'(b_error), 16'd0);
    adv(11); @(negedge clk);
    chk("b_to_err", 16'(b_error), 16'd1);
    chk("b_to_en", 16'(b_enable), 16'd0);
    chk("b_to_busy", 16'(b_busy), 16'd0);
    chk("b_to_idx", 16'(b_rom_index), 16'd0);

    // Instance B: single entry with start held, restarts right after DONE
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); rel = 0;
    adv(1); @(negedge clk);
    chk("b1_en", 16'(b_enable), 16'd1);
    chk("b1_err_clr", 16'(b_error), 16'd0);
    chk("b1_addr", 16'(b_periph_addr), 16'h20);
    adv(2); #1 ctrl_b = 4'd3;
    adv(3); @(negedge clk);
    chk("b1_en_drop", 16'(b_enable), 16'd0);
    adv(5); #1 ctrl_b = 4'd0;
    @(negedge clk); chk("b1_wait_busy", 16'(b_busy), 16'd1);
    adv(6); @(negedge clk);
    chk("b1_done", 16'(b_done), 16'd1);
    chk("b1_done_busy", 16'(b_busy), 16'd0);
    chk("b1_done_idx", 16'(b_rom_index), 16'd0);
    adv(7); @(negedge clk);
    chk("b1_reload_done", 16'(b_done), 16'd0);
    chk("b1_reload_busy", 16'(b_busy), 16'd1);
    chk("b1_reload_en", 16'(b_enable), 16'd0);
    adv(8); @(negedge clk);
    chk("b1_re_en", 16'(b_enable), 16'd1);
    #1 start_b = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
